// File: rtl/swin_lbuf.sv
// Sliding-window line buffer: K-1 line memories in a ring plus the live input row
// form a K-row window column per accepted beat, with valid/ready flow control.
module swin_lbuf #(
   parameter int PIX_W   = 8,
   parameter int PPB     = 16,
   parameter int K       = 3,
   parameter int LINE_AW = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sof,
   input  logic [LINE_AW:0]         cfg_line_beats,
   input  logic [PIX_W*PPB-1:0]     in_data,
   input  logic                     in_vld,
   output logic                     in_rdy,
   output logic [K*PIX_W*PPB-1:0]   out_line,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [LINE_AW-1:0]       out_col,
   output logic                     out_sol,
   output logic                     out_eol,
   output logic                     cfg_err
);

   localparam int BW        = PIX_W * PPB;
   localparam int NMEM      = K - 1;
   localparam int MAX_BEATS = 2 ** LINE_AW;
   localparam int WPW       = (NMEM > 1) ? $clog2(NMEM) : 1;
   localparam int RW        = $clog2(K);

   typedef enum logic [1:0] {IDLE, FILL, RUN, ERR} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [LINE_AW-1:0]   r_col;
   logic [WPW-1:0]       r_wp;
   logic [RW-1:0]        r_rows;
   logic [LINE_AW:0]     r_L;
   logic                 r_cfg_err;
   logic                 r_out_vld;
   logic [K*BW-1:0]      r_out_line;
   logic [LINE_AW-1:0]   r_out_col;
   logic                 r_out_sol;
   logic                 r_out_eol;

   logic                 w_acc;
   logic                 w_last;
   logic                 w_cfg_ok;
   logic [NMEM*BW-1:0]   w_rd_line;

   logic [BW-1:0]        r_mem [NMEM][MAX_BEATS];

   assign w_cfg_ok = (cfg_line_beats != '0) &&
                     (cfg_line_beats <= (LINE_AW+1)'(MAX_BEATS));
   assign w_last   = ({1'b0, r_col} == (r_L - (LINE_AW+1)'(1)));
   assign w_acc    = in_vld && in_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (sof)
         w_state_nxt = w_cfg_ok ? FILL : ERR;
      else if (r_state == FILL && w_acc && w_last && r_rows == RW'(K-2))
         w_state_nxt = RUN;
   end

   always_comb begin
      in_rdy = (r_state == FILL || r_state == RUN) && !sof && (!r_out_vld || out_rdy);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_wp      <= '0;
         r_rows    <= '0;
         r_L       <= '0;
         r_cfg_err <= 1'b0;
      end else if (sof) begin
         r_col     <= '0;
         r_wp      <= '0;
         r_rows    <= '0;
         r_L       <= cfg_line_beats;
         r_cfg_err <= !w_cfg_ok;
      end else if (w_acc) begin
         if (w_last) begin
            r_col <= '0;
            r_wp  <= (r_wp == WPW'(NMEM-1)) ? '0 : r_wp + 1'b1;
            if (r_rows != RW'(K-1)) r_rows <= r_rows + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Line memories carry no reset; K-1 fresh rows are always written before any read is used.
   always_ff @(posedge clk) begin
      if (w_acc) r_mem[r_wp][r_col] <= in_data;
   end

   // Slot r_wp holds the oldest row at this column; walk the ring from there.
   always_comb begin
      logic [WPW:0] w_idx;
      w_rd_line = '0;
      w_idx     = '0;
      for (int unsigned j = 0; j < NMEM; j++) begin
         w_idx = {1'b0, r_wp} + (WPW+1)'(j);
         if (w_idx >= (WPW+1)'(NMEM)) w_idx = w_idx - (WPW+1)'(NMEM);
         w_rd_line[j*BW +: BW] = r_mem[w_idx[WPW-1:0]][r_col];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld  <= 1'b0;
         r_out_line <= '0;
         r_out_col  <= '0;
         r_out_sol  <= 1'b0;
         r_out_eol  <= 1'b0;
      end else if (sof) begin
         r_out_vld  <= 1'b0;
      end else if (w_acc && r_state == RUN) begin
         r_out_vld  <= 1'b1;
         r_out_line <= {in_data, w_rd_line};
         r_out_col  <= r_col;
         r_out_sol  <= (r_col == '0);
         r_out_eol  <= w_last;
      end else if (out_rdy) begin
         r_out_vld  <= 1'b0;
      end
   end

   assign out_vld  = r_out_vld;
   assign out_line = r_out_line;
   assign out_col  = r_out_col;
   assign out_sol  = r_out_sol;
   assign out_eol  = r_out_eol;
   assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_swin_lbuf.sv
// Directed and randomized bench for swin_lbuf (PIX_W=8, PPB=2, K=3, LINE_AW=3)
// against a frame-history reference model.
module tb_swin_lbuf;

   localparam int K  = 3;
   localparam int BW = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sof = 1'b0;
   logic [3:0]  cfg_line_beats = '0;
   logic [15:0] in_data = '0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [47:0] out_line;
   logic        out_vld;
   logic        out_rdy = 1'b0;
   logic [2:0]  out_col;
   logic        out_sol;
   logic        out_eol;
   logic        cfg_err;

   swin_lbuf #(.PIX_W(8), .PPB(2), .K(K), .LINE_AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .sof(sof), .cfg_line_beats(cfg_line_beats),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_line(out_line), .out_vld(out_vld), .out_rdy(out_rdy),
      .out_col(out_col), .out_sol(out_sol), .out_eol(out_eol), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: beats accepted since sof, line length, and every pixel beat of the frame.
   int          n = 0;
   int          mL = 0;
   bit          m_act = 0, m_err = 0, m_vld = 0;
   logic [47:0] m_line = '0;
   int          m_col = 0;
   bit          m_sol = 0, m_eol = 0;
   logic [15:0] hist [0:511][0:7];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pat();
      logic [7:0] v;
      if (mL == 0) return 16'hdead;
      v = 8'((n / mL) * 16 + (n % mL));
      return {v, v};
   endfunction

   task automatic cyc(input bit s, input logic [3:0] cfg, input bit v,
                      input logic [15:0] d, input bit rdy);
      bit exp_rdy, acc;
      int row, col;
      sof = s; cfg_line_beats = cfg; in_vld = v; in_data = d; out_rdy = rdy;
      #1;
      exp_rdy = m_act && !s && (!m_vld || rdy);
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      if (s) begin
         n = 0; m_vld = 0; mL = int'(cfg);
         m_act = (cfg >= 1 && cfg <= 8);
         m_err = !m_act;
      end else if (acc) begin
         row = n / mL; col = n % mL;
         hist[row][col] = d;
         if (row >= K-1) begin
            m_vld = 1;
            for (int j = 0; j < K-1; j++) m_line[j*BW +: BW] = hist[row-(K-1)+j][col];
            m_line[(K-1)*BW +: BW] = d;
            m_col = col; m_sol = (col == 0); m_eol = (col == mL-1);
         end else if (rdy) m_vld = 0;
         n++;
      end else if (rdy) m_vld = 0;
      #1;
      chk("out_vld", 64'(out_vld), 64'(m_vld));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      if (m_vld) begin
         chk("out_line", 64'(out_line), 64'(m_line));
         chk("out_col",  64'(out_col),  64'(m_col));
         chk("out_sol",  64'(out_sol),  64'(m_sol));
         chk("out_eol",  64'(out_eol),  64'(m_eol));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #2;
      chk("rst_out_vld",  64'(out_vld),  64'd0);
      chk("rst_in_rdy",   64'(in_rdy),   64'd0);
      chk("rst_out_line", 64'(out_line), 64'd0);
      chk("rst_out_col",  64'(out_col),  64'd0);
      chk("rst_cfg_err",  64'(cfg_err),  64'd0);
      #6 rst_n = 1'b1;
      cyc(0, 4, 1, 16'h1234, 1);                       // IDLE ignores beats

      // Warm-up: sof coinciding with a beat, then 12 beats
      cyc(1, 4, 1, 16'hffff, 1);
      for (int i = 0; i < 9; i++) cyc(0, 4, 1, pat(), 1);
      chk("warm_c0_line", 64'(out_line), 64'h2020_1010_0000);
      chk("warm_c0_sol",  64'(out_sol),  64'd1);
      for (int i = 0; i < 3; i++) cyc(0, 4, 1, pat(), 1);
      chk("warm_c3_line", 64'(out_line), 64'h2323_1313_0303);
      chk("warm_c3_eol",  64'(out_eol),  64'd1);

      // Ring wrap: rows 3 and 4
      for (int i = 0; i < 5; i++) cyc(0, 4, 1, pat(), 1);
      chk("wrap_r4_line", 64'(out_line), 64'h4040_3030_2020);
      for (int i = 0; i < 3; i++) cyc(0, 4, 1, pat(), 1);

      // Backpressure mid-row with gaps in input
      for (int i = 0; i < 2; i++) cyc(0, 4, 1, pat(), 1);
      for (int i = 0; i < 5; i++) cyc(0, 4, 1, pat(), 0);
      for (int i = 0; i < 6; i++) cyc(0, 4, (i != 2), pat(), 1);

      // sof mid-frame while output is pending
      cyc(1, 4, 0, 16'h0, 1);
      for (int i = 0; i < 10; i++) cyc(0, 4, 1, pat(), 1);
      cyc(1, 4, 1, 16'hbeef, 0);
      for (int i = 0; i < 9; i++) cyc(0, 4, 1, pat(), 1);

      // Illegal configs, then the boundary lengths
      cyc(1, 0, 0, 16'h0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'haaaa, 1);
      cyc(1, 9, 1, 16'h5555, 1);
      cyc(0, 9, 1, 16'h5555, 1);
      cyc(1, 8, 0, 16'h0, 1);
      for (int i = 0; i < 26; i++) cyc(0, 8, 1, pat(), (i % 3) != 1);
      cyc(1, 1, 0, 16'h0, 1);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, pat(), 1);
      cyc(1, 4, 0, 16'h0, 1);

      // Randomized traffic with occasional re-sof
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2)
            cyc(1, 4'($urandom_range(0, 9)), $urandom_range(0, 1) == 1, 16'($urandom), 1);
         else
            cyc(0, 4'(mL), $urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6);
      end

      // Asynchronous reset while output is held
      cyc(1, 2, 0, 16'h0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 2, 1, pat(), 0);
      chk("pre_rst_vld", 64'(out_vld), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_vld",  64'(out_vld),  64'd0);
      chk("arst_in_rdy",   64'(in_rdy),   64'd0);
      chk("arst_out_line", 64'(out_line), 64'd0);
      chk("arst_out_col",  64'(out_col),  64'd0);
      n = 0; mL = 0; m_act = 0; m_err = 0; m_vld = 0;
      #3 rst_n = 1'b1;
      cyc(0, 2, 1, 16'h7777, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
